// File: rtl/noc_pkg.sv
// Shared types and constants for the processing-element side of the NoC mesh.
// Covers configure word layout, command codes, request payload and sender FSM states.
package noc_pkg;

    localparam int unsigned NODE_W       = 2;
    localparam int unsigned DATA_W       = 7;
    localparam int unsigned CMD_W        = 2;
    localparam int unsigned CFG_W        = CMD_W + DATA_W + NODE_W;
    localparam int unsigned SENT_W       = 8;
    localparam int unsigned ERR_W        = 2;
    localparam int unsigned FIFO_DEPTH   = 4;

    localparam int unsigned CFG_DEST_LSB = 0;
    localparam int unsigned CFG_DATA_LSB = CFG_DEST_LSB + NODE_W;
    localparam int unsigned CFG_CMD_LSB  = CFG_DATA_LSB + DATA_W;

    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_SELF     = 1;

    // Command codes 2'b10 and 2'b11 are reserved on the mesh and never driven.
    typedef enum logic [CMD_W-1:0] {
        CMD_IDLE = 2'b00,
        CMD_SEND = 2'b01
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [NODE_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    function automatic logic [CFG_W-1:0] make_cfg(input cmd_t cmd, input req_t req);
        logic [CFG_W-1:0] word;
        word                           = '0;
        word[CFG_CMD_LSB  +: CMD_W]    = cmd;
        word[CFG_DATA_LSB +: DATA_W]   = req.data;
        word[CFG_DEST_LSB +: NODE_W]   = req.dest;
        return word;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Small synchronous show-ahead FIFO; simultaneous push and pop both take effect.
module noc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/noc_pe_sender.sv
// Processor-side mesh sender: queues core requests and drives SEND configure words,
// holding each until net_ready or a stall-aware timeout, then idling for a fixed gap.
module noc_pe_sender
    import noc_pkg::*;
#(
    parameter int SRC_ID     = 0,
    parameter int HOLD_MAX   = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [NODE_W-1:0] req_dest,
    input  logic [DATA_W-1:0] req_data,
    input  logic              net_ready,
    input  logic              block_all_paths,
    output logic [CFG_W-1:0]  configure,
    output logic              busy,
    output logic [SENT_W-1:0] sent_count,
    output logic [ERR_W-1:0]  err_pulse
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam state_t      AFTER_HOLD = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CFG_W-1:0]  cfg_d;
    logic [SENT_W-1:0] sent_d;
    logic [ERR_W-1:0]  err_d;
    logic              ready_d;
    logic              busy_d;

    logic              push;
    logic              pop;
    req_t              wr_req;
    req_t              head;
    logic [REQ_W-1:0]  fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_d;

    assign wr_req = '{dest: req_dest, data: req_data};
    assign head   = req_t'(fifo_rd);
    assign push   = req_valid && req_ready;

    noc_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_req),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        cfg_d   = configure;
        sent_d  = sent_count;
        err_d   = '0;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !block_all_paths) begin
                    pop = 1'b1;
                    if (head.dest == NODE_W'(SRC_ID)) begin
                        err_d[ERR_SELF] = 1'b1;
                    end else begin
                        cfg_d   = make_cfg(CMD_SEND, head);
                        wait_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (net_ready) begin
                    sent_d  = sent_count + SENT_W'(1);
                    cfg_d   = '0;
                    wait_d  = '0;
                    gap_d   = '0;
                    state_d = AFTER_HOLD;
                end else if (!block_all_paths) begin
                    // Timeout budget only advances while the mesh is not globally stalled.
                    if (wait_q == WAIT_W'(HOLD_MAX - 1)) begin
                        err_d[ERR_TIMEOUT] = 1'b1;
                        cfg_d   = '0;
                        wait_d  = '0;
                        gap_d   = '0;
                        state_d = AFTER_HOLD;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cfg_d   = '0;
            end
        endcase

        count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d  = (count_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            gap_q      <= '0;
            configure  <= '0;
            sent_count <= '0;
            err_pulse  <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            configure  <= cfg_d;
            sent_count <= sent_d;
            err_pulse  <= err_d;
            req_ready  <= ready_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_noc_pe_sender.sv
// Self-checking bench for noc_pe_sender (SRC_ID=2): vector table plus multi-cycle sequences.
module tb_noc_pe_sender;
    import noc_pkg::*;

    localparam int SRC = 2;
    localparam int NVEC = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest;
    logic [6:0]  req_data;
    logic        net_ready;
    logic        block_all_paths;
    logic [10:0] configure;
    logic        busy;
    logic [7:0]  sent_count;
    logic [1:0]  err_pulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    noc_pe_sender #(.SRC_ID(SRC), .HOLD_MAX(64), .GAP_CYCLES(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dest        (req_dest),
        .req_data        (req_data),
        .net_ready       (net_ready),
        .block_all_paths (block_all_paths),
        .configure       (configure),
        .busy            (busy),
        .sent_count      (sent_count),
        .err_pulse       (err_pulse)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  dest;
        logic [6:0]  data;
        logic        nr;
        logic        blk;
        logic [10:0] cfg;
        logic        rdy;
        logic        bsy;
        logic [7:0]  sent;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic [1:0] d, input logic [6:0] x,
                                input logic nr, input logic blk, input logic [10:0] cfg,
                                input logic rdy, input logic bsy, input logic [7:0] sent,
                                input logic [1:0] err);
        vec_t r;
        r.valid = v;   r.dest = d;   r.data = x;   r.nr = nr;     r.blk = blk;
        r.cfg   = cfg; r.rdy  = rdy; r.bsy  = bsy; r.sent = sent; r.err = err;
        return r;
    endfunction

    // Expected SEND word: {cmd=01, data, dest}.
    function automatic logic [10:0] w(input logic [1:0] d, input logic [6:0] x);
        return {2'b01, x, d};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        req_valid       = 1'b0;
        req_dest        = 2'd0;
        req_data        = 7'd0;
        net_ready       = 1'b0;
        block_all_paths = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, output bit ok);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    initial begin
        int  held;
        int  zeros;
        int  idx;
        int  budget;
        bit  ok;
        bit  stuck;

        reset = 1'b1;
        idle_inputs();

        // Table: sent counts assume a fresh reset; ready stays high throughout.
        tbl[0]  = mk(1, 2'd3, 7'h00, 1, 0, 11'h000,     1, 1, 8'd0, 2'b00);
        tbl[1]  = mk(0, 2'd0, 7'h00, 1, 0, w(3, 7'h00), 1, 1, 8'd0, 2'b00);
        tbl[2]  = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd1, 2'b00);
        tbl[3]  = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd1, 2'b00);
        tbl[4]  = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 0, 8'd1, 2'b00);
        tbl[5]  = mk(1, 2'd2, 7'h05, 1, 0, 11'h000,     1, 1, 8'd1, 2'b00);
        tbl[6]  = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 0, 8'd1, 2'b10);
        tbl[7]  = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 0, 8'd1, 2'b00);
        tbl[8]  = mk(1, 2'd1, 7'h7f, 0, 0, 11'h000,     1, 1, 8'd1, 2'b00);
        tbl[9]  = mk(0, 2'd0, 7'h00, 0, 0, w(1, 7'h7f), 1, 1, 8'd1, 2'b00);
        tbl[10] = mk(0, 2'd0, 7'h00, 0, 0, w(1, 7'h7f), 1, 1, 8'd1, 2'b00);
        tbl[11] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd2, 2'b00);
        tbl[12] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd2, 2'b00);
        tbl[13] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 0, 8'd2, 2'b00);
        tbl[14] = mk(1, 2'd0, 7'h2a, 1, 1, 11'h000,     1, 1, 8'd2, 2'b00);
        tbl[15] = mk(0, 2'd0, 7'h00, 1, 1, 11'h000,     1, 1, 8'd2, 2'b00);
        tbl[16] = mk(0, 2'd0, 7'h00, 0, 0, w(0, 7'h2a), 1, 1, 8'd2, 2'b00);
        tbl[17] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd3, 2'b00);
        tbl[18] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 1, 8'd3, 2'b00);
        tbl[19] = mk(0, 2'd0, 7'h00, 1, 0, 11'h000,     1, 0, 8'd3, 2'b00);

        tick();
        tick();
        check("rst.configure", 32'(configure), 32'h0);
        check("rst.req_ready", 32'(req_ready), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.sent_count", 32'(sent_count), 32'h0);
        check("rst.err_pulse", 32'(err_pulse), 32'h0);
        reset = 1'b0;
        tick();
        check("rst.ready_rise", 32'(req_ready), 32'h1);

        for (int i = 0; i < NVEC; i++) begin
            req_valid       = tbl[i].valid;
            req_dest        = tbl[i].dest;
            req_data        = tbl[i].data;
            net_ready       = tbl[i].nr;
            block_all_paths = tbl[i].blk;
            tick();
            check($sformatf("v%0d.configure", i), 32'(configure), 32'(tbl[i].cfg));
            check($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
            check($sformatf("v%0d.sent_count", i), 32'(sent_count), 32'(tbl[i].sent));
            check($sformatf("v%0d.err_pulse", i), 32'(err_pulse), 32'(tbl[i].err));
        end
        idle_inputs();

        // Fill the FIFO while pops are blocked; fifth request waits for the first pop.
        block_all_paths = 1'b1;
        req_valid = 1'b1;
        req_dest  = 2'd1;
        for (int k = 0; k < 4; k++) begin
            req_data = 7'(16 + k);
            tick();
        end
        req_data = 7'(20);
        check("fill.ready_low", 32'(req_ready), 32'h0);
        tick();
        check("fill.ready_held_low", 32'(req_ready), 32'h0);
        check("fill.busy", 32'(busy), 32'h1);
        block_all_paths = 1'b0;
        tick();
        check("fill.ready_after_pop", 32'(req_ready), 32'h1);
        check("fill.first_word", 32'(configure), 32'(w(1, 7'(16))));
        tick();
        req_valid = 1'b0;
        check("fill.ready_after_fifth", 32'(req_ready), 32'h0);
        net_ready = 1'b1;
        idx = 1;
        budget = 0;
        while (idx < 5 && budget < 100) begin
            tick();
            budget++;
            if (configure != 11'h000) begin
                check($sformatf("fill.order%0d", idx), 32'(configure), 32'(w(1, 7'(16 + idx))));
                idx++;
            end
        end
        check("fill.all_sent", 32'(idx), 32'd5);
        wait_not_busy(50, ok);
        check("fill.drained", 32'(ok), 32'h1);
        check("fill.sent_count", 32'(sent_count), 32'd8);
        net_ready = 1'b0;

        // Timeout with a second request queued behind it.
        req_valid = 1'b1;
        req_dest  = 2'd0;
        req_data  = 7'h33;
        tick();
        req_data  = 7'h34;
        tick();
        req_valid = 1'b0;
        held = 0;
        while (configure == w(0, 7'h33) && held < 200) begin
            held++;
            tick();
        end
        check("tmo.held_cycles", 32'(held), 32'd64);
        check("tmo.configure", 32'(configure), 32'h0);
        check("tmo.err_pulse", 32'(err_pulse), 32'h1);
        zeros = 0;
        while (configure == 11'h000 && zeros < 20) begin
            zeros++;
            tick();
        end
        // Two GAP cycles plus the IDLE cycle in which the next word is popped.
        check("tmo.gap_zeros", 32'(zeros), 32'd3);
        check("tmo.next_word", 32'(configure), 32'(w(0, 7'h34)));
        check("tmo.err_cleared", 32'(err_pulse), 32'h0);
        check("tmo.sent_unchanged", 32'(sent_count), 32'd8);

        // Second word times out with a 10-cycle global stall in the middle of HOLD.
        held = 0;
        while (configure == w(0, 7'h34) && held < 200) begin
            held++;
            if (held == 20) block_all_paths = 1'b1;
            if (held == 30) block_all_paths = 1'b0;
            tick();
        end
        check("stall.held_cycles", 32'(held), 32'd74);
        check("stall.err_pulse", 32'(err_pulse), 32'h1);
        wait_not_busy(50, ok);
        check("stall.drained", 32'(ok), 32'h1);

        // Reset asserted in the middle of HOLD.
        req_valid = 1'b1;
        req_dest  = 2'd3;
        req_data  = 7'h55;
        tick();
        req_valid = 1'b0;
        tick();
        check("rhold.in_hold", 32'(configure), 32'(w(3, 7'h55)));
        reset = 1'b1;
        tick();
        check("rhold.configure", 32'(configure), 32'h0);
        check("rhold.busy", 32'(busy), 32'h0);
        check("rhold.sent_count", 32'(sent_count), 32'h0);
        check("rhold.err_pulse", 32'(err_pulse), 32'h0);
        check("rhold.req_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;
        tick();
        check("rhold.ready_rise", 32'(req_ready), 32'h1);
        check("rhold.no_resend", 32'(configure), 32'h0);

        // 256 completed transfers wrap sent_count back to zero.
        net_ready = 1'b1;
        stuck = 1'b0;
        for (int i = 0; i < 256; i++) begin
            req_valid = 1'b1;
            req_dest  = 2'd3;
            req_data  = 7'(i);
            tick();
            req_valid = 1'b0;
            wait_not_busy(20, ok);
            if (!ok) stuck = 1'b1;
            if (i == 254) check("wrap.at_255", 32'(sent_count), 32'd255);
        end
        check("wrap.no_stall", 32'(stuck), 32'h0);
        check("wrap.sent_count", 32'(sent_count), 32'h0);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_pe_sender.md
NOC_PE_SENDER -- requirements
Module: noc_pe_sender

Interface
REQ-001 SHALL have parameter SRC_ID, default 0: this processor's node id (0..3).
REQ-002 SHALL have parameter HOLD_MAX, default 64: maximum cycles a SEND word is held awaiting net_ready.
REQ-003 SHALL have parameter GAP_CYCLES, default 2: idle cycles driven between consecutive SEND words.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  core offers a send request.
REQ-007 SHALL have port req_ready  output  1  sender accepts request this cycle.
REQ-008 SHALL have port req_dest  input  2  destination node id.
REQ-009 SHALL have port req_data  input  7  payload.
REQ-010 SHALL have port net_ready  input  1  this processor's ready signal from the mesh.
REQ-011 SHALL have port block_all_paths  input  1  global mesh stall.
REQ-012 SHALL have port configure  output  11  configure word to the mesh, layout {cmd[10:9], data[8:2], dest[1:0]}.
REQ-013 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-014 SHALL have port sent_count  output  8  completed transfers, wraps 255->0.
REQ-015 SHALL have port err_pulse  output  2  one-cycle pulse: bit0 timeout drop, bit1 self-destination drop.

Function
REQ-016 SHALL accept a request when req_valid and req_ready are both high at a rising edge; req_ready = FIFO not full (registered, independent of same-cycle pop).
REQ-017 SHALL buffer requests in a 4-entry FIFO, order preserved; push and pop in the same cycle both take effect.
REQ-018 SHALL use FSM states IDLE, HOLD, GAP.
REQ-019 IDLE: if FIFO non-empty and block_all_paths low, pop head; dest==SRC_ID -> pulse err_pulse[1], stay IDLE; else register SEND word (cmd=01) on configure, go HOLD.
REQ-020 HOLD: configure held stable; net_ready high at an edge completes transfer: sent_count+1, configure<=0, go GAP.
REQ-021 HOLD: wait counter increments each cycle block_all_paths is low and is frozen while high; on reaching HOLD_MAX without net_ready: configure<=0, pulse err_pulse[0], go GAP.
REQ-022 GAP: configure=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-023 Latency: with FSM IDLE, FIFO empty, unblocked, SEND word SHALL appear on configure 2 cycles after the accepting edge.
REQ-024 configure SHALL be 0 (cmd=00) in IDLE and GAP; cmds 10/11 reserved, never driven.
REQ-025 net_ready outside HOLD SHALL be ignored.
REQ-026 block_all_paths high in IDLE SHALL prevent pops; FIFO still accepts pushes.

Reset
REQ-027 reset high at an edge SHALL clear FIFO, FSM->IDLE, configure=0, req_ready=0, busy=0, sent_count=0, err_pulse=0, wait counter=0, regardless of state (including mid-HOLD).
REQ-028 req_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-029 Package noc_pkg SHALL hold cmd codes (IDLE=00, SEND=01), field widths, configure word bit positions, node-id width.
REQ-030 FIFO SHALL be a sub-module noc_fifo (parameterised width/depth, full/empty flags); FSM and counters in noc_pe_sender.

Verification
REQ-031 SRC_ID=2, push dest=3 data=0x00 with net_ready tied high -> configure=11'b01000000011 two cycles later for one cycle, sent_count=1, then 2 zero cycles.
REQ-032 Push 5 requests back-to-back, net_ready low -> req_ready low after 4 accepted; 5th accepted once the first pop occurs.
REQ-033 net_ready never high -> SEND word held 64 cycles, then configure=0, err_pulse=01, next request issued after GAP.
REQ-034 block_all_paths high 10 cycles mid-HOLD, net_ready low -> timeout at cycle 74 of HOLD, not 64.
REQ-035 Push dest==SRC_ID -> err_pulse=10 one cycle, configure stays 0, sent_count unchanged.
REQ-036 Assert reset during HOLD -> next cycle configure=0, busy=0, counts 0; 256 transfers -> sent_count wraps to 0.
